conv2d_post_16: RTL
===================

CONV2D_POST_16 -- requirements
Module: conv2d_post_16

Interface
REQ-001 Parameter bitsize, default 14: width of every signed sum, bias and output word.
REQ-002 Parameter NUM_CH, default 16: channels per input beat; fixed at 16 in this revision.
REQ-003 Parameter FRAC_BITS, default 8: fractional bits of the fixed-point format, used for the ReLU6 limit.
REQ-004 clk  input  1: single clock; all state updates on its rising edge.
REQ-005 rst  input  1: reset, asynchronous, active-high.
REQ-006 data_in  input  bitsize*16: signed sums; channel i occupies bits [i*bitsize +: bitsize].
REQ-007 valid_in  input  1: data_in holds a beat of 16 sums this cycle.
REQ-008 in_ready  output  1: the block accepts a beat this cycle.
REQ-009 bias  input  bitsize*16: signed per-channel bias, same packing as data_in, sampled with the beat.
REQ-010 act_sel  input  2: activation code, sampled with the beat; 00 identity, 01 ReLU, 10 ReLU6, 11 identity.
REQ-011 data_out  output  bitsize: signed result of the channel currently presented.
REQ-012 ch_idx  output  4: index of the channel on data_out.
REQ-013 valid_out  output  1: data_out and ch_idx are valid.
REQ-014 out_ready  input  1: downstream accepts data_out this cycle.
REQ-015 last_out  output  1: high with valid_out when ch_idx=15.
REQ-016 overrun_err  output  1: sticky flag; a beat arrived while in_ready was low.

Function
REQ-017 Per channel, the block SHALL form s = sext(data_in_i) + sext(bias_i) at bitsize+1 bits, then saturate to [-2^(bitsize-1), 2^(bitsize-1)-1].
REQ-018 Activation SHALL apply to the saturated value: ReLU gives max(0,s); ReLU6 gives min(max(0,s), 6<<FRAC_BITS); codes 00 and 11 pass s through.
REQ-019 The FSM SHALL have two states: IDLE and STREAM.
REQ-020 in_ready SHALL equal (state==IDLE) | (state==STREAM & ch_idx==15 & out_ready).
REQ-021 A beat SHALL be accepted when valid_in & in_ready; all 16 post-activation results are then registered into a 16-entry buffer, and the next state is STREAM with ch_idx=0.
REQ-022 Latency SHALL be 1 cycle: a beat accepted at edge N gives valid_out=1 with channel 0 after edge N.
REQ-023 In STREAM, valid_out SHALL be 1 and data_out SHALL be buf[ch_idx]; ch_idx increments only on an edge with out_ready=1.
REQ-024 If out_ready=0, data_out, ch_idx and valid_out SHALL hold their values.
REQ-025 If ch_idx=15, out_ready=1 and no beat is accepted, the next state SHALL be IDLE with valid_out=0 and ch_idx=0.
REQ-026 If ch_idx=15, out_ready=1 and valid_in=1 in the same cycle, the new beat SHALL be accepted and streaming continues at ch_idx=0 with no bubble.
REQ-027 If valid_in=1 while in_ready=0, the beat SHALL be dropped, overrun_err set, and the buffer and stream left undisturbed.
REQ-028 overrun_err SHALL clear only on reset.
REQ-029 In IDLE, data_out SHALL be 0, ch_idx 0, valid_out 0 and last_out 0.

Reset
REQ-030 While rst=1, asynchronously: state IDLE, ch_idx 0, buffer all 0, data_out 0, valid_out 0, last_out 0, overrun_err 0.
REQ-031 Reset asserted mid-stream SHALL abort the stream; remaining channels are discarded and not replayed.
REQ-032 After release, in_ready SHALL be 1 in the first cycle.

Structure
REQ-033 The shared package/header SHALL hold the act_sel codes (ACT_ID, ACT_RELU, ACT_RELU6) and the state encodings (ST_IDLE, ST_STREAM).
REQ-034 One combinational sub-module, post_act_1 (bias add, saturate, activation for one channel), SHALL be instantiated 16 times by generate.
REQ-035 The buffer, channel counter and FSM SHALL reside in conv2d_post_16.

Verification (bitsize=14, FRAC_BITS=8)
REQ-036 ch0 sum 100, bias -30, act 00, out_ready=1 -> valid_out one cycle after accept, data_out=70, ch_idx=0; 16 consecutive outputs with last_out only at ch_idx=15.
REQ-037 Saturation: sum 8000, bias 500 -> 8191; sum -8000, bias -500 -> -8192 (act 00).
REQ-038 Activation: s=-200 with ReLU -> 0; s=2000 with ReLU6 -> 1536; s=1000 with ReLU6 -> 1000.
REQ-039 out_ready held 0 for 5 cycles at ch_idx=3 -> data_out and ch_idx stable; then a valid_in pulse gives overrun_err=1 with the stream unchanged.
REQ-040 Back-to-back beats with valid_in at ch_idx=15 & out_ready -> 32 consecutive valid_out cycles and no idle cycle.
REQ-041 rst pulsed at ch_idx=7 -> all outputs 0 immediately, then in_ready=1 and a fresh beat streams from ch_idx=0.

Source files
------------

// File: rtl/conv2d_post_16_pkg.sv
// Shared encodings for the conv2d post-processing block: activation codes and FSM states.
// Pure declarations; no latency or flow-control behaviour lives here.
package conv2d_post_16_pkg;

  localparam logic [1:0] ACT_ID     = 2'b00;
  localparam logic [1:0] ACT_RELU   = 2'b01;
  localparam logic [1:0] ACT_RELU6  = 2'b10;
  localparam logic [1:0] ACT_ID_ALT = 2'b11;

  localparam int CH_W = 4;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/conv2d_post_16_post_act.sv
// One channel of bias add, saturate to bitsize, then activation; purely combinational.
// Zero latency and no flow control: the parent samples the result when it accepts a beat.
module post_act_1 #(
  parameter int bitsize   = 14,
  parameter int FRAC_BITS = 8
) (
  input  logic signed [bitsize-1:0] sum_in,
  input  logic signed [bitsize-1:0] bias_in,
  input  logic        [1:0]         act_sel,
  output logic signed [bitsize-1:0] res
);
  import conv2d_post_16_pkg::*;

  localparam logic signed [bitsize-1:0] SAT_MAX   = {1'b0, {(bitsize-1){1'b1}}};
  localparam logic signed [bitsize-1:0] SAT_MIN   = {1'b1, {(bitsize-1){1'b0}}};
  localparam logic signed [bitsize-1:0] RELU6_MAX = bitsize'(6 << FRAC_BITS);

  logic signed [bitsize:0]   sum_ext;
  logic signed [bitsize-1:0] sat;

  always_comb begin
    sum_ext = {sum_in[bitsize-1], sum_in} + {bias_in[bitsize-1], bias_in};
    // Top two bits disagree only when the sum left the bitsize range.
    if (sum_ext[bitsize] != sum_ext[bitsize-1]) begin
      sat = sum_ext[bitsize] ? SAT_MIN : SAT_MAX;
    end else begin
      sat = sum_ext[bitsize-1:0];
    end

    res = sat;
    case (act_sel)
      ACT_RELU: begin
        if (sat[bitsize-1]) res = '0;
      end
      ACT_RELU6: begin
        if (sat[bitsize-1]) begin
          res = '0;
        end else if (sat > RELU6_MAX) begin
          res = RELU6_MAX;
        end
      end
      default: res = sat;
    endcase
  end

endmodule

// File: rtl/conv2d_post_16.sv
// Accepts 16 channel sums per beat, post-processes them in parallel, then streams one channel per cycle.
// Latency 1 cycle to channel 0; a new beat is only taken when idle or as channel 15 leaves, so it never stalls the stream.
module conv2d_post_16
  import conv2d_post_16_pkg::*;
#(
  parameter int bitsize   = 14,
  parameter int NUM_CH    = 16,
  parameter int FRAC_BITS = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [bitsize*NUM_CH-1:0] data_in,
  input  logic                      valid_in,
  output logic                      in_ready,
  input  logic [bitsize*NUM_CH-1:0] bias,
  input  logic [1:0]                act_sel,
  output logic [bitsize-1:0]        data_out,
  output logic [CH_W-1:0]           ch_idx,
  output logic                      valid_out,
  input  logic                      out_ready,
  output logic                      last_out,
  output logic                      overrun_err
);

  localparam logic [CH_W-1:0] CH_LAST = CH_W'(NUM_CH - 1);

  state_t                    state_q, state_d;
  logic [CH_W-1:0]           ch_idx_q, ch_idx_d;
  logic [bitsize-1:0]        buf_q [NUM_CH];
  logic [bitsize-1:0]        buf_d [NUM_CH];
  logic [bitsize-1:0]        data_out_q, data_out_d;
  logic                      valid_out_q, valid_out_d;
  logic                      last_out_q, last_out_d;
  logic                      overrun_err_q, overrun_err_d;

  logic signed [bitsize-1:0] post_res [NUM_CH];
  logic [CH_W-1:0]           ch_inc;
  logic                      at_last;
  logic                      accept;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    post_act_1 #(
      .bitsize  (bitsize),
      .FRAC_BITS(FRAC_BITS)
    ) u_post_act (
      .sum_in (data_in[g*bitsize +: bitsize]),
      .bias_in(bias[g*bitsize +: bitsize]),
      .act_sel(act_sel),
      .res    (post_res[g])
    );
  end

  assign ch_inc   = ch_idx_q + 1'b1;
  assign at_last  = (state_q == ST_STREAM) && (ch_idx_q == CH_LAST);
  assign in_ready = (state_q == ST_IDLE) || (at_last && out_ready);
  assign accept   = valid_in && in_ready;

  always_comb begin
    state_d       = state_q;
    ch_idx_d      = ch_idx_q;
    data_out_d    = data_out_q;
    valid_out_d   = valid_out_q;
    last_out_d    = last_out_q;
    overrun_err_d = overrun_err_q || (valid_in && !in_ready);
    for (int i = 0; i < NUM_CH; i++) begin
      buf_d[i] = buf_q[i];
    end

    if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        buf_d[i] = post_res[i];
      end
      state_d     = ST_STREAM;
      ch_idx_d    = '0;
      data_out_d  = post_res[0];
      valid_out_d = 1'b1;
      last_out_d  = 1'b0;
    end else if (state_q == ST_STREAM && out_ready) begin
      if (at_last) begin
        state_d     = ST_IDLE;
        ch_idx_d    = '0;
        data_out_d  = '0;
        valid_out_d = 1'b0;
        last_out_d  = 1'b0;
      end else begin
        ch_idx_d   = ch_inc;
        data_out_d = buf_q[ch_inc];
        last_out_d = (ch_inc == CH_LAST);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ch_idx_q      <= '0;
      data_out_q    <= '0;
      valid_out_q   <= 1'b0;
      last_out_q    <= 1'b0;
      overrun_err_q <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ch_idx_q      <= ch_idx_d;
      data_out_q    <= data_out_d;
      valid_out_q   <= valid_out_d;
      last_out_q    <= last_out_d;
      overrun_err_q <= overrun_err_d;
      for (int i = 0; i < NUM_CH; i++) begin
        buf_q[i] <= buf_d[i];
      end
    end
  end

  assign data_out    = data_out_q;
  assign ch_idx      = ch_idx_q;
  assign valid_out   = valid_out_q;
  assign last_out    = last_out_q;
  assign overrun_err = overrun_err_q;

endmodule
